rtc_bcd_timer: RTL and testbench

Parametrised successor to the team's free-running HH:MM time-of-day counter. It keeps BCD time as hours, minutes and seconds from a configurable clock prescaler. It also provides a 4-bit CPU register port for setting and reading time, a run/stop control, a 12/24-hour display mode and an optional minute-resolution alarm. It sits between the system clock and the 7-segment display driver, and hangs off the CPU peripheral bus.

---
 rtl/rtc_bcd_timer.sv | 232 +++++++++++++++++++++++
 tb/tb_rtc_bcd_timer.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_bcd_timer.sv
// BCD time-of-day counter (HH:MM:SS) with prescaler, CPU register port, 12/24 h display.
// Optional minute-resolution alarm is compiled in when RTC_ALARM_EN is defined.
module rtc_bcd_timer #(
   parameter int TICK_DIV = 50000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sel,
   input  logic       write_en,
   input  logic [3:0] address,
   input  logic [3:0] data_in,
   output logic [3:0] data_out,
   output logic       sec_tick,
   output logic [1:0] hour1,
   output logic [3:0] hour0,
   output logic [2:0] min1,
   output logic [3:0] min0,
   output logic [2:0] sec1,
   output logic [3:0] sec0,
   output logic       pm,
   output logic       alarm_irq
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] CMAX = CW'(TICK_DIV - 1);

   logic [CW-1:0] c;
   logic [3:0] t_s0, t_m0, t_h0;
   logic [2:0] t_s1, t_m1;
   logic [1:0] t_h1;
   logic       run, mode12, alarm_en;

   logic [3:0] n_s0, n_m0, n_h0;
   logic [2:0] n_s1, n_m1;
   logic [1:0] n_h1;
   logic       cy_s0, cy_s1, cy_m0, cy_m1;

   logic wr, rd, time_wr, due, tick;
   logic [3:0] rdata;
   logic [5:0] hb, dh;

   assign wr      = sel & write_en;
   assign rd      = sel & ~write_en;
   assign time_wr = wr & (address <= 4'd5);
   assign due     = run & (c == CMAX);
   // a register write on the tick edge discards the whole tick
   assign tick    = due & ~wr;

   always_comb begin
      n_s0  = t_s0;
      n_s1  = t_s1;
      n_m0  = t_m0;
      n_m1  = t_m1;
      n_h0  = t_h0;
      n_h1  = t_h1;
      cy_s0 = (t_s0 >= 4'd9);
      cy_s1 = cy_s0 & (t_s1 >= 3'd5);
      cy_m0 = cy_s1 & (t_m0 >= 4'd9);
      cy_m1 = cy_m0 & (t_m1 >= 3'd5);
      n_s0  = cy_s0 ? 4'd0 : t_s0 + 4'd1;
      if (cy_s0)
         n_s1 = (t_s1 >= 3'd5) ? 3'd0 : t_s1 + 3'd1;
      if (cy_s1)
         n_m0 = (t_m0 >= 4'd9) ? 4'd0 : t_m0 + 4'd1;
      if (cy_m0)
         n_m1 = (t_m1 >= 3'd5) ? 3'd0 : t_m1 + 3'd1;
      if (cy_m1) begin
         if (t_h1 == 2'd3 || (t_h1 == 2'd2 && t_h0 >= 4'd3)) begin
            n_h1 = 2'd0;
            n_h0 = 4'd0;
         end else if (t_h0 >= 4'd9) begin
            n_h1 = t_h1 + 2'd1;
            n_h0 = 4'd0;
         end else begin
            n_h0 = t_h0 + 4'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         c <= '0;
      end else if (time_wr || (wr && due)) begin
         c <= '0;
      end else if (run) begin
         c <= due ? '0 : c + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         t_s0 <= '0;
         t_s1 <= '0;
         t_m0 <= '0;
         t_m1 <= '0;
         t_h0 <= '0;
         t_h1 <= '0;
      end else if (time_wr) begin
         case (address)
            4'd0:    t_s0 <= data_in;
            4'd1:    t_s1 <= data_in[2:0];
            4'd2:    t_m0 <= data_in;
            4'd3:    t_m1 <= data_in[2:0];
            4'd4:    t_h0 <= data_in;
            default: t_h1 <= data_in[1:0];
         endcase
      end else if (tick) begin
         t_s0 <= n_s0;
         t_s1 <= n_s1;
         t_m0 <= n_m0;
         t_m1 <= n_m1;
         t_h0 <= n_h0;
         t_h1 <= n_h1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sec_tick <= 1'b0;
         run      <= 1'b1;
         mode12   <= 1'b0;
      end else begin
         sec_tick <= tick;
         if (wr && address == 4'd6) begin
            run    <= data_in[0];
            mode12 <= data_in[1];
         end
      end
   end

`ifdef RTC_ALARM_EN
   logic [3:0] a_m0, a_h0;
   logic [2:0] a_m1;
   logic [1:0] a_h1;
   logic       a_en, a_irq, a_hit, a_clr;

   assign alarm_en  = a_en;
   assign alarm_irq = a_irq;
   assign a_clr     = wr & (address == 4'd6) & data_in[3];
   assign a_hit     = tick & a_en & (n_s1 == 3'd0) & (n_s0 == 4'd0) &
                      ({n_h1, n_h0, n_m1, n_m0} == {a_h1, a_h0, a_m1, a_m0});

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_m0  <= '0;
         a_m1  <= '0;
         a_h0  <= '0;
         a_h1  <= '0;
         a_en  <= 1'b0;
         a_irq <= 1'b0;
      end else begin
         if (wr) begin
            case (address)
               4'd6:    a_en <= data_in[2];
               4'd8:    a_m0 <= data_in;
               4'd9:    a_m1 <= data_in[2:0];
               4'd10:   a_h0 <= data_in;
               4'd11:   a_h1 <= data_in[1:0];
               default: ;
            endcase
         end
         // set beats clear on a coincident edge
         if (a_hit)
            a_irq <= 1'b1;
         else if (a_clr)
            a_irq <= 1'b0;
      end
   end
`else
   assign alarm_en  = 1'b0;
   assign alarm_irq = 1'b0;
`endif

   assign hb = 6'(t_h1) * 6'd10 + 6'(t_h0);

   always_comb begin
      pm    = 1'b0;
      dh    = hb;
      hour1 = t_h1;
      hour0 = t_h0;
      if (mode12) begin
         if (hb == 6'd0) begin
            dh = 6'd12;
         end else if (hb >= 6'd12) begin
            pm = 1'b1;
            if (hb > 6'd12)
               dh = hb - 6'd12;
         end
         if (dh >= 6'd10) begin
            hour1 = 2'd1;
            hour0 = 4'(dh - 6'd10);
         end else begin
            hour1 = 2'd0;
            hour0 = dh[3:0];
         end
      end
   end

   assign min1 = t_m1;
   assign min0 = t_m0;
   assign sec1 = t_s1;
   assign sec0 = t_s0;

   always_comb begin
      rdata = 4'd0;
      case (address)
         4'd0:    rdata = t_s0;
         4'd1:    rdata = {1'b0, t_s1};
         4'd2:    rdata = t_m0;
         4'd3:    rdata = {1'b0, t_m1};
         4'd4:    rdata = t_h0;
         4'd5:    rdata = {2'b00, t_h1};
         4'd6:    rdata = {1'b0, alarm_en, mode12, run};
         4'd7:    rdata = {2'b00, pm, alarm_irq};
`ifdef RTC_ALARM_EN
         4'd8:    rdata = a_m0;
         4'd9:    rdata = {1'b0, a_m1};
         4'd10:   rdata = a_h0;
         4'd11:   rdata = {2'b00, a_h1};
`endif
         default: rdata = 4'd0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         data_out <= 4'd0;
      else if (rd)
         data_out <= rdata;
   end

endmodule

// File: tb/tb_rtc_bcd_timer.sv
// Bench for rtc_bcd_timer: directed steps plus random traffic against a
// seconds-of-day reference model.
module tb_rtc_bcd_timer;

   localparam int TD = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sel = 1'b0;
   logic       write_en = 1'b0;
   logic [3:0] address = 4'd0;
   logic [3:0] data_in = 4'd0;
   logic [3:0] data_out;
   logic       sec_tick;
   logic [1:0] hour1;
   logic [3:0] hour0;
   logic [2:0] min1;
   logic [3:0] min0;
   logic [2:0] sec1;
   logic [3:0] sec0;
   logic       pm;
   logic       alarm_irq;

   rtc_bcd_timer #(.TICK_DIV(TD)) dut (
      .clk(clk), .rst(rst), .sel(sel), .write_en(write_en),
      .address(address), .data_in(data_in), .data_out(data_out),
      .sec_tick(sec_tick), .hour1(hour1), .hour0(hour0),
      .min1(min1), .min0(min0), .sec1(sec1), .sec0(sec0),
      .pm(pm), .alarm_irq(alarm_irq)
   );

   always #5 clk = ~clk;

   int nassert = 0;
   int nfail = 0;

   // reference model: time as seconds of day, prescaler as an integer
   int secs, cc;
   bit run, m12, alen, irq, model_ok;
   int am0, am1, ah0, ah1;
   int exp_dout;
   bit exp_tick;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nassert++;
      assert (got === exp) else begin
         nfail++;
         $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      secs = 0; cc = 0; run = 1; m12 = 0; alen = 0; irq = 0;
      am0 = 0; am1 = 0; ah0 = 0; ah1 = 0;
      exp_dout = 0; exp_tick = 0;
   endtask

   function automatic int disp_hour();
      int h;
      h = secs / 3600;
      if (!m12) return h;
      return (h % 12 == 0) ? 12 : h % 12;
   endfunction

   function automatic int model_read(input int a);
      int h, m, s;
      h = secs / 3600; m = (secs / 60) % 60; s = secs % 60;
      case (a)
         0: return s % 10;
         1: return s / 10;
         2: return m % 10;
         3: return m / 10;
         4: return h % 10;
         5: return h / 10;
         6: return alen * 4 + m12 * 2 + run;
         7: return (m12 && h >= 12) * 2 + irq;
`ifdef RTC_ALARM_EN
         8: return am0;
         9: return am1;
         10: return ah0;
         11: return ah1;
`endif
         default: return 0;
      endcase
   endfunction

   task automatic set_digit(input int a, input int d);
      int h, m, s;
      h = secs / 3600; m = (secs / 60) % 60; s = secs % 60;
      case (a)
         0: s = (s / 10) * 10 + (d & 15);
         1: s = (d & 7) * 10 + s % 10;
         2: m = (m / 10) * 10 + (d & 15);
         3: m = (d & 7) * 10 + m % 10;
         4: h = (h / 10) * 10 + (d & 15);
         default: h = (d & 3) * 10 + h % 10;
      endcase
      secs = h * 3600 + m * 60 + s;
   endtask

   task automatic check_outputs();
      int dh;
      dh = disp_hour();
      chk("sec_tick", 32'(sec_tick), exp_tick);
      chk("data_out", 32'(data_out), exp_dout);
      if (model_ok) begin
         chk("hour1", 32'(hour1), dh / 10);
         chk("hour0", 32'(hour0), dh % 10);
         chk("min1", 32'(min1), ((secs / 60) % 60) / 10);
         chk("min0", 32'(min0), ((secs / 60) % 60) % 10);
         chk("sec1", 32'(sec1), (secs % 60) / 10);
         chk("sec0", 32'(sec0), (secs % 60) % 10);
         chk("pm", 32'(pm), (m12 && secs >= 12 * 3600) ? 1 : 0);
         chk("alarm_irq", 32'(alarm_irq), irq);
      end
   endtask

   task automatic step(input bit s, input bit w, input int a, input int d);
      bit wr, due, tk;
      sel = s; write_en = w; address = 4'(a); data_in = 4'(d);
      @(posedge clk);
      wr  = s && w;
      due = run && cc == TD - 1;
      tk  = due && !wr;
      if (s && !w) exp_dout = model_read(a);
      if ((wr && a <= 5) || (wr && due)) cc = 0;
      else if (run) cc = due ? 0 : cc + 1;
      if (wr) begin
         if (a <= 5) set_digit(a, d);
         if (a == 6) begin
            run = d[0]; m12 = d[1];
`ifdef RTC_ALARM_EN
            alen = d[2];
            if (d[3]) irq = 0;
`endif
         end
`ifdef RTC_ALARM_EN
         if (a == 8) am0 = d & 15;
         if (a == 9) am1 = d & 7;
         if (a == 10) ah0 = d & 15;
         if (a == 11) ah1 = d & 3;
`endif
      end
      if (tk) begin
         secs = (secs + 1) % 86400;
`ifdef RTC_ALARM_EN
         if (alen && secs % 60 == 0 &&
             secs / 60 == (ah1 * 10 + ah0) * 60 + am1 * 10 + am0)
            irq = 1;
`endif
      end
      exp_tick = tk;
      #1;
      check_outputs();
   endtask

   task automatic idle(input int n);
      repeat (n) step(0, 0, 0, 0);
   endtask

   task automatic wreg(input int a, input int d);
      step(1, 1, a, d);
   endtask

   task automatic rreg(input int a);
      step(1, 0, a, 0);
   endtask

   task automatic set_time(input int h, input int m, input int s);
      wreg(5, 0);
      wreg(4, h % 10);
      wreg(5, h / 10);
      wreg(3, m / 10);
      wreg(2, m % 10);
      wreg(1, s / 10);
      wreg(0, s % 10);
   endtask

   task automatic wait_tick(input int maxc, input string tag);
      bit seen;
      seen = 0;
      for (int i = 0; i < maxc && !seen; i++) begin
         idle(1);
         if (sec_tick === 1'b1) seen = 1;
      end
      chk(tag, 32'(seen), 1);
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_dout"}, 32'(data_out), 0);
      chk({tag, "_tick"}, 32'(sec_tick), 0);
      chk({tag, "_time"}, 32'({hour1, hour0, min1, min0, sec1, sec0}), 0);
      chk({tag, "_pm"}, 32'(pm), 0);
      chk({tag, "_irq"}, 32'(alarm_irq), 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int t, op, n;
      model_ok = 1;
      model_reset();
      #2 rst = 1'b0;
      #1 check_reset_values("reset");
      @(negedge clk);
      rst = 1'b1;

      // first tick exactly TD edges after release, then a full minute
      idle(TD - 1);
      step(0, 0, 0, 0);
      chk("first_tick", 32'(sec_tick), 1);
      idle(59 * TD);
      chk("minute_min0", 32'(min0), 1);
      chk("minute_sec", 32'({sec1, sec0}), 0);

      // midnight rollover
      set_time(23, 59, 59);
      wait_tick(TD + 2, "midnight_tick");
      chk("midnight_time", 32'({hour1, hour0, min1, min0, sec1, sec0}), 0);

      // 12 h display mapping
      wreg(6, 4'b0011);
      set_time(13, 5, 0);
      chk("m12_13_h1", 32'(hour1), 0);
      chk("m12_13_h0", 32'(hour0), 1);
      chk("m12_13_pm", 32'(pm), 1);
      set_time(0, 30, 0);
      chk("m12_00_h1", 32'(hour1), 1);
      chk("m12_00_h0", 32'(hour0), 2);
      chk("m12_00_pm", 32'(pm), 0);
      rreg(7);
      wreg(6, 4'b0001);

      // write landing on the tick edge
      set_time(0, 0, 7);
      idle(TD - 1);
      wreg(0, 3);
      chk("collide_sec0", 32'(sec0), 3);
      chk("collide_tick", 32'(sec_tick), 0);
      idle(TD - 1);
      step(0, 0, 0, 0);
      chk("collide_next", 32'(sec0), 4);

      // run/stop
      idle(2);
      wreg(6, 4'b0000);
      t = secs;
      idle(100);
      chk("frozen_sec0", 32'(sec0), (t % 60) % 10);
      wreg(6, 4'b0001);
      wait_tick(TD + 2, "resume_tick");

      // out-of-range digits roll on '>='
      set_time(0, 0, 0);
      model_ok = 0;
      wreg(0, 12);
      wait_tick(TD + 2, "oor_sec_tick");
      chk("oor_sec", 32'({sec1, sec0}), 32'h10);
      wreg(5, 3); wreg(4, 0); wreg(3, 5); wreg(2, 9); wreg(1, 5); wreg(0, 9);
      wait_tick(TD + 2, "oor_hour_tick");
      chk("oor_hour", 32'({hour1, hour0, min1, min0, sec1, sec0}), 0);
      set_time(1, 2, 3);
      model_ok = 1;

`ifdef RTC_ALARM_EN
      set_time(0, 1, 58);
      wreg(8, 2); wreg(9, 0); wreg(10, 0); wreg(11, 0);
      wreg(6, 4'b0101);
      rreg(8);
      chk("alarm_read", 32'(data_out), 2);
      wait_tick(TD + 2, "alarm_t1");
      wait_tick(TD + 2, "alarm_t2");
      chk("alarm_set", 32'(alarm_irq), 1);
      idle(10);
      chk("alarm_sticky", 32'(alarm_irq), 1);
      wreg(6, 4'b1101);
      chk("alarm_clear", 32'(alarm_irq), 0);
      set_time(0, 2, 0);
      chk("alarm_timewrite", 32'(alarm_irq), 0);
      wreg(6, 4'b0001);
`else
      rreg(8);
      chk("alarm_absent_read", 32'(data_out), 0);
      chk("alarm_absent_irq", 32'(alarm_irq), 0);
`endif

      // random traffic
      for (int it = 0; it < 60; it++) begin
         op = int'($urandom_range(0, 5));
         case (op)
            0: idle(int'($urandom_range(1, 12)));
            1: begin
               t = int'($urandom_range(0, 86399));
               set_time(t / 3600, (t / 60) % 60, t % 60);
            end
            2: rreg(int'($urandom_range(0, 15)));
            3: begin
               n = int'($urandom_range(0, 3));
               wreg(6, ($urandom_range(0, 1) << 3) | ($urandom_range(0, 1) << 1) |
                       ((n != 0) ? 1 : 0));
            end
            4: wreg(int'($urandom_range(12, 15)), int'($urandom_range(0, 15)));
            default: step(0, 1, int'($urandom_range(0, 5)), int'($urandom_range(0, 9)));
         endcase
      end
      wreg(6, 4'b0001);
      idle(3 * TD);

      // reset in the middle of a second
      set_time(12, 34, 56);
      rreg(3);
      idle(2);
      #2 rst = 1'b0;
      #1 check_reset_values("midreset");
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      idle(TD - 1);
      step(0, 0, 0, 0);
      chk("midreset_first_tick", 32'(sec_tick), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
      $finish;
   end

endmodule
